// File: rtl/mem_stage_access_if.sv
// Data-memory (dcache) request/response bundle between the MEM stage and the dcache.
// master: the MEM stage issuing requests. slave: the data memory answering them.
interface mem_stage_access_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access: issues dcache requests, builds byte enables and
// lane-replicated store data, extends load data, and stalls the pipeline until
// the access completes.
//
// state | meaning
// IDLE  | no access outstanding; a new legal access is requested combinationally
// BUSY  | request issued, waiting for dmem_resp
// HOLD  | access done but pipeline frozen by ext_stall; do not reissue
module mem_stage_access #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_mem_read,
  input  logic             MEM_mem_write,
  input  logic [2:0]       MEM_funct3,
  input  logic [width-1:0] MEM_aluout,
  input  logic [width-1:0] MEM_rs2,
  input  logic             ext_stall,
  mem_stage_access_if.master dmem,
  output logic [width-1:0] MEM_rdata,
  output logic             mem_stall,
  output logic             misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state_q;
  logic [31:0] rdata_q;

  logic        is_load, is_store, access;
  logic        legal, aligned, req;
  logic        issue, resp_acc;
  logic [1:0]  offset;
  logic [31:0] raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A simultaneous read+write is treated as a load; the write is dropped.
  assign is_load  = MEM_mem_read;
  assign is_store = MEM_mem_write & ~MEM_mem_read;
  assign access   = MEM_mem_read | MEM_mem_write;
  assign offset   = MEM_aluout[1:0];

  // Legality of funct3 for the access kind and natural alignment of the size.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (MEM_funct3)
      3'b000, 3'b001, 3'b010: legal = is_load | is_store;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
    case (MEM_funct3[1:0])
      2'b01:   aligned = ~offset[0];
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign req        = access & legal & aligned;
  assign misaligned = access & ~(legal & aligned);

  // Requests are gated by reset so they drop the instant reset asserts, and
  // never reissued once the access has completed (HOLD).
  assign issue    = req & ~rst & (state_q != HOLD);
  assign resp_acc = issue & dmem.dmem_resp;

  assign dmem.dmem_read    = issue & is_load;
  assign dmem.dmem_write   = issue & is_store;
  assign dmem.dmem_address = {MEM_aluout[31:2], 2'b00};
  assign mem_stall         = issue & ~dmem.dmem_resp;

  // Byte enables and store lane replication by access size and offset.
  always_comb begin
    dmem.dmem_byte_enable = 4'b0000;
    case (MEM_funct3[1:0])
      2'b00:   dmem.dmem_wdata = {4{MEM_rs2[7:0]}};
      2'b01:   dmem.dmem_wdata = {2{MEM_rs2[15:0]}};
      default: dmem.dmem_wdata = MEM_rs2;
    endcase
    if (dmem.dmem_write) begin
      case (MEM_funct3[1:0])
        2'b00:   dmem.dmem_byte_enable = 4'b0001 << offset;
        2'b01:   dmem.dmem_byte_enable = 4'b0011 << offset;
        default: dmem.dmem_byte_enable = 4'b1111;
      endcase
    end
  end

  // Load data: live response in the completion cycle, captured word afterwards.
  assign raw      = resp_acc ? dmem.dmem_rdata : rdata_q;
  assign half_sel = offset[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    case (offset)
      2'b00:   byte_sel = raw[7:0];
      2'b01:   byte_sel = raw[15:8];
      2'b10:   byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  // Sign/zero extension of the selected lane; zero when not a legal load.
  always_comb begin
    MEM_rdata = '0;
    if (req & is_load) begin
      case (MEM_funct3)
        3'b000:  MEM_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  MEM_rdata = {24'h0, byte_sel};
        3'b001:  MEM_rdata = {{16{half_sel[15]}}, half_sel};
        3'b101:  MEM_rdata = {16'h0, half_sel};
        3'b010:  MEM_rdata = raw;
        default: MEM_rdata = '0;
      endcase
    end
  end

  // Access sequencing and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      if (resp_acc) rdata_q <= dmem.dmem_rdata;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (!dmem.dmem_resp)  state_q <= BUSY;
            else if (ext_stall)   state_q <= HOLD;
          end
        end
        BUSY: begin
          if (!req)                 state_q <= IDLE;
          else if (dmem.dmem_resp)  state_q <= ext_stall ? HOLD : IDLE;
        end
        HOLD: begin
          if (!ext_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Memory-access stage, directly downstream of the EX/MEM pipeline buffer.
- Consumes the MEM-stage ALU result (address), rs2 value and load/store control.
- Drives the data-memory (dcache) request/response handshake, generates byte enables and store-data lane replication, and sign/zero-extends load data.
- Raises the stall that freezes the pipeline buffers until the access completes.

Parameters:
width, 32, data/address width; only 32 is supported.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
MEM_mem_read  in  1  instruction in MEM is a load
MEM_mem_write  in  1  instruction in MEM is a store
MEM_funct3  in  3  RV32I load/store funct3
MEM_aluout  in  32  effective byte address
MEM_rs2  in  32  store source value
ext_stall  in  1  pipeline stall from any other source (hazard unit / icache)
dmem_read  out  1  data memory read request
dmem_write  out  1  data memory write request
dmem_address  out  32  word-aligned address, {MEM_aluout[31:2],2'b00}
dmem_byte_enable  out  4  write byte lanes
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid when dmem_resp=1
dmem_resp  in  1  access complete (single-cycle pulse)
MEM_rdata  out  32  extended load result for WB
mem_stall  out  1  MEM access pending; freezes IF..EX/MEM buffers
misaligned  out  1  current access is misaligned or has an illegal funct3; it is suppressed

Behaviour:
- Access request: req = (MEM_mem_read | MEM_mem_write) & legal & aligned. Upstream holds all MEM_* inputs stable while mem_stall=1.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 on an access is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- Illegal or misaligned access (combinational):
  - misaligned=1, no dmem request, mem_stall=0, MEM_rdata=0.
  - FSM stays IDLE.
- FSM states: IDLE, BUSY, HOLD. Reset state is IDLE.
- IDLE:
  - dmem_read/dmem_write = req & MEM_mem_read / MEM_mem_write, asserted combinationally in the same cycle the instruction arrives.
  - If req & !dmem_resp: go to BUSY.
  - If req & dmem_resp & ext_stall: go to HOLD.
  - Otherwise stay in IDLE.
- BUSY:
  - Request held asserted.
  - On dmem_resp: go to HOLD if ext_stall, else IDLE.
- HOLD:
  - Access already complete; request deasserted; mem_stall=0.
  - Go to IDLE in the first cycle ext_stall=0 (pipeline advances that edge).
  - The same instruction is never reissued.
- mem_stall = req & !dmem_resp in IDLE/BUSY; 0 in HOLD. It drops in the dmem_resp cycle.
- Read data capture:
  - rdata_q <= dmem_rdata on every dmem_resp accepted in IDLE/BUSY.
  - Raw word = dmem_resp ? dmem_rdata : rdata_q.
- Load extension (o = addr[1:0]):
  - LB: sign-extend byte o.
  - LBU: zero-extend byte o.
  - LH: sign-extend halfword at o[1].
  - LHU: zero-extend halfword at o[1].
  - LW: word unchanged.
  - MEM_rdata=0 when no load.
- Stores:
  - SB: byte_enable=4'b0001<<o, wdata = rs2[7:0] replicated x4.
  - SH: byte_enable=4'b0011<<o, wdata = rs2[15:0] x2.
  - SW: byte_enable=4'b1111, wdata = rs2.
  - byte_enable=0 when dmem_write=0.
- dmem_resp while no request is pending (IDLE without req, or HOLD) is ignored: no state or data change.
- Simultaneous read and write asserted: the read takes priority, dmem_write=0. This is illegal control, but the behaviour is defined.
- Async reset, including mid-access:
  - State=IDLE and rdata_q=0 immediately.
  - dmem_read/dmem_write/mem_stall drop in the same cycle the reset asserts, independent of clk.
  - A response from the aborted access arriving after reset release is ignored unless a new req is active.
- Latency: zero added cycles beyond the memory. A 1-cycle dcache hit (resp in the same cycle) produces no stall.

Test Plan:
- LW addr 0x100, dmem_resp 3 cycles later, rdata 0xDEADBEEF -> mem_stall=1 for 3 cycles; MEM_rdata=0xDEADBEEF in resp cycle; dmem_read drops next cycle.
- LB addr 0x103 rdata 0x80112233 -> MEM_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SB addr 0x201 rs2=0x000000AB -> byte_enable=0010, wdata=0xABABABAB, address=0x200; SH addr 0x202 rs2=0x1234 -> enable=1100, wdata=0x12341234.
- LW addr 0x102 -> misaligned=1, dmem_read=0, mem_stall=0, MEM_rdata=0.
- LW resp with ext_stall=1 for 2 further cycles, rdata 0x55AA55AA -> exactly one dmem_read transaction; MEM_rdata=0x55AA55AA held while in HOLD; IDLE after ext_stall falls.
- Reset asserted in BUSY, then a stale dmem_resp with no req -> outputs 0 immediately; state IDLE; rdata_q stays 0.
